// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects and strobes, with a watchdog on every memory handshake.
module multicycle_main_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       fault,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WB   = 4'd5,
        MEM_WR   = 4'd6,
        R_EXEC   = 4'd7,
        R_WB     = 4'd8,
        I_EXEC   = 4'd9,
        I_WB     = 4'd10,
        BRANCH   = 4'd11,
        JAL      = 4'd12,
        JR       = 4'd13,
        FAULT    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);
    localparam logic            WDOG_EN = (MEM_TIMEOUT != 0);

    state_t          cur, nxt;
    logic [TO_W-1:0] to_cnt;
    logic            waiting;
    logic            timed_out;

    // A memory-facing state stalls while the handshake is outstanding; mem_ready wins over the limit.
    assign waiting   = ((cur == FETCH) || (cur == MEM_RD) || (cur == MEM_WR)) && !mem_ready;
    assign timed_out = waiting && WDOG_EN && (to_cnt == TO_LIM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur    <= IDLE;
            to_cnt <= '0;
        end else begin
            cur <= nxt;
            if (nxt != cur)
                to_cnt <= '0;
            else if (waiting && WDOG_EN)
                to_cnt <= to_cnt + 1'b1;
        end
    end

    always_comb begin
        nxt = cur;
        if (timed_out) begin
            nxt = FAULT;
        end else begin
            case (cur)
                IDLE:     nxt = FETCH;
                FETCH:    if (mem_ready) nxt = DECODE;
                DECODE: begin
                    case (opcode)
                        OP_RTYPE:         nxt = (funct == FN_JR) ? JR : R_EXEC;
                        OP_LW, OP_SW:     nxt = MEM_ADDR;
                        OP_BEQ:           nxt = BRANCH;
                        OP_JAL:           nxt = JAL;
                        OP_ADDI, OP_ANDI: nxt = I_EXEC;
                        default:          nxt = FETCH;
                    endcase
                end
                MEM_ADDR: nxt = (opcode == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD:   if (mem_ready) nxt = MEM_WB;
                MEM_WR:   if (mem_ready) nxt = FETCH;
                R_EXEC:   nxt = R_WB;
                I_EXEC:   nxt = I_WB;
                MEM_WB, R_WB, I_WB, BRANCH, JAL, JR: nxt = FETCH;
                FAULT:    nxt = FAULT;
                default:  nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        instr_done    = 1'b0;
        fault         = 1'b0;
        case (cur)
            FETCH: begin
                mem_read  = 1'b1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                alu_src_b = 2'b01;
            end
            DECODE:   alu_src_b = 2'b11;
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                instr_done = 1'b1;
            end
            MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                instr_done = 1'b1;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b10;
            end
            I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
            // Link value comes from the PC before this edge's jump load.
            JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                instr_done = 1'b1;
            end
            JR: begin
                pc_write   = 1'b1;
                pc_source  = 2'b11;
                instr_done = 1'b1;
            end
            FAULT:   fault = 1'b1;
            default: ;
        endcase
    end

    assign state = cur;

endmodule
